load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-memory access engine for the MEM stage.
// Two-state FSM (IDLE/ACCESS) with byte-lane steering, load extension and ack timeout.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (adds the 'misaligned' output; no bus request is issued for a trapped access).
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        bus_err
`ifdef LSU_MISALIGN_TRAP_EN
  , output logic      misaligned
`endif
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [31:0] load_data_q, load_data_d;
  logic        mis_q, mis_d;

  logic        accept, timeout, mis_in;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata, ext_data, rd_shift;

  assign accept  = (state_q == IDLE) & valid_in & (MemRead_in | MemWrite_in);
  // Abort when the last allowed wait cycle passes without an ack; ack wins a tie.
  assign timeout = (state_q == ACCESS) & ~dmem_ack & (cnt_q == 8'(ACK_TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  // funct3[1] selects word; funct3[1:0]==01 selects half.
  assign mis_in = ((funct3_in[1:0] == 2'b01) & addr_in[0]) |
                  (funct3_in[1] & (addr_in[1:0] != 2'b00));
  assign misaligned = mis_q;
`else
  assign mis_in = 1'b0;
`endif

  // Store lane steering from the latched request; sub-size address bits are ignored.
  always_comb begin
    lane_strb  = 4'b1111;
    lane_wdata = data_q;
    if (f3_q[1]) begin
      lane_strb  = 4'b1111;
      lane_wdata = data_q;
    end else if (f3_q[0]) begin
      lane_strb  = addr_q[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{data_q[15:0]}};
    end else begin
      lane_strb  = 4'b0001 << addr_q[1:0];
      lane_wdata = {4{data_q[7:0]}};
    end
  end

  // Load extraction: align the selected byte/half to bit 0, then extend.
  always_comb begin
    rd_shift = f3_q[0] ? (dmem_rdata >> {addr_q[1], 4'b0000})
                       : (dmem_rdata >> {addr_q[1:0], 3'b000});
    case (f3_q)
      3'b000:  ext_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  ext_data = {24'h0, rd_shift[7:0]};
      3'b001:  ext_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  ext_data = {16'h0, rd_shift[15:0]};
      default: ext_data = dmem_rdata;
    endcase
  end

  // Next-state logic: accept in IDLE, wait for ack or timeout in ACCESS.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    f3_d        = f3_q;
    we_d        = we_q;
    load_data_d = load_data_q;
    mis_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mis_in) begin
            mis_d = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = 8'd0;
            addr_d  = addr_in;
            data_d  = store_data_in;
            f3_d    = funct3_in;
            we_d    = MemWrite_in;  // read+write together is a store
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d = IDLE;
          if (!we_q) load_data_d = ext_data;
        end else if (timeout) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      f3_q        <= 3'd0;
      we_q        <= 1'b0;
      load_data_q <= 32'd0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      load_data_q <= load_data_d;
      mis_q       <= mis_d;
    end
  end

  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = lane_wdata;
  assign dmem_wstrb = dmem_we ? lane_strb : 4'b0000;
  assign stall      = accept | dmem_req;
  assign done       = (dmem_req & (dmem_ack | timeout)) | mis_q;
  assign bus_err    = timeout;
  assign load_data  = load_data_q;

endmodule
